// File: rtl/neuron_pkg.sv
// Shared neuron types and the ReLU mask helper, so the forward ReLU and the
// backward mask recorder apply an identical saturation test.
package neuron_pkg;

   typedef struct packed {
      logic active;
      logic sat;
   } relu_mask_t;

   localparam int MAX_SUM_WIDTH = 64;

   // Caller zero-extends the sum into x; only bits below sum_width are examined.
   function automatic relu_mask_t relu_mask_of(input logic [MAX_SUM_WIDTH-1:0] x,
                                               input int sum_width,
                                               input int int_width);
      relu_mask_t m;
      m.active = ~x[sum_width-1];
      m.sat    = 1'b0;
      for (int i = 0; i < MAX_SUM_WIDTH; i++) begin
         if ((i >= sum_width - 1 - int_width) && (i < sum_width)) begin
            m.sat = m.sat | x[i];
         end else begin
            m.sat = m.sat;
         end
      end
      m.sat = m.sat & m.active;
      return m;
   endfunction

endpackage

// File: rtl/relu_backward_if.sv
// Forward-sample, upstream-gradient and masked-gradient streams of relu_backward.
interface relu_backward_if #(
   parameter int DATA_WIDTH = 16
);
   logic                      fwd_valid;
   logic [2*DATA_WIDTH-1:0]   fwd_x;
   logic                      fwd_ready;
   logic                      bwd_in_valid;
   logic [DATA_WIDTH-1:0]     bwd_in_grad;
   logic                      bwd_in_ready;
   logic                      bwd_out_valid;
   logic [DATA_WIDTH-1:0]     bwd_out_grad;
   logic                      bwd_out_ready;

   modport slave (
      input  fwd_valid, fwd_x, bwd_in_valid, bwd_in_grad, bwd_out_ready,
      output fwd_ready, bwd_in_ready, bwd_out_valid, bwd_out_grad
   );

   modport master (
      output fwd_valid, fwd_x, bwd_in_valid, bwd_in_grad, bwd_out_ready,
      input  fwd_ready, bwd_in_ready, bwd_out_valid, bwd_out_grad
   );
endinterface

// File: rtl/relu_mask_fifo.sv
// Flop-array FIFO of ReLU masks with combinational read at the read pointer.
module relu_mask_fifo
   import neuron_pkg::*;
#(
   parameter  int DEPTH = 64,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             push_i,
   input  relu_mask_t       wdata_i,
   input  logic             pop_i,
   output relu_mask_t       rdata_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);
   relu_mask_t       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_s, pop_s;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + {{(PTR_W-1){1'b0}}, 1'b1};
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == {CNT_W{1'b0}});
   assign push_s  = push_i & ~full_o & ~clear;
   assign pop_s   = pop_i & ~empty_o & ~clear;
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Pointer and occupancy next state; clear wins over any push or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         count_d  = {CNT_W{1'b0}};
      end else begin
         if (push_s) wr_ptr_d = next_ptr(wr_ptr_q);
         else        wr_ptr_d = wr_ptr_q;
         if (pop_s)  rd_ptr_d = next_ptr(rd_ptr_q);
         else        rd_ptr_d = rd_ptr_q;
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Mask storage; contents are only meaningful behind the pointers.
   always_ff @(posedge clk) begin
      if (push_s) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/relu_backward.sv
// ReLU backward pass: records forward masks, then passes or zeroes upstream
// gradients through a one-deep registered valid/ready output stage.
module relu_backward
   import neuron_pkg::*;
#(
   parameter  int dataWidth      = 16,
   parameter  int weightIntWidth = 4,
   parameter  int depth          = 64,
   parameter  bit zeroOnSat      = 1'b1,
   localparam int CNT_W          = $clog2(depth + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   relu_backward_if.slave   bus,
   output logic [CNT_W-1:0] count,
   output logic             err_overflow,
   output logic             err_underflow
);
   relu_mask_t           fwd_mask_s, fifo_mask_s;
   logic                 full_s, empty_s, push_s, pop_s, pass_s;
   logic                 out_valid_q, out_valid_d;
   logic [dataWidth-1:0] out_grad_q, out_grad_d;
   logic                 err_ovf_q, err_ovf_d, err_unf_q, err_unf_d;

   assign fwd_mask_s = relu_mask_of(MAX_SUM_WIDTH'(bus.fwd_x), 2 * dataWidth, weightIntWidth);
   assign push_s     = bus.fwd_valid & ~full_s;
   assign pop_s      = bus.bwd_in_valid & bus.bwd_in_ready;
   assign pass_s     = fifo_mask_s.active & ~(fifo_mask_s.sat & zeroOnSat);

   assign bus.fwd_ready     = ~full_s;
   assign bus.bwd_in_ready  = ~empty_s & (~out_valid_q | bus.bwd_out_ready);
   assign bus.bwd_out_valid = out_valid_q;
   assign bus.bwd_out_grad  = out_grad_q;
   assign err_overflow      = err_ovf_q;
   assign err_underflow     = err_unf_q;

   relu_mask_fifo #(.DEPTH(depth)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .push_i  (push_s),
      .wdata_i (fwd_mask_s),
      .pop_i   (pop_s),
      .rdata_o (fifo_mask_s),
      .count_o (count),
      .full_o  (full_s),
      .empty_o (empty_s)
   );

   // Output stage and sticky error flags; the grad register survives clear.
   always_comb begin
      out_valid_d = out_valid_q;
      out_grad_d  = out_grad_q;
      err_ovf_d   = err_ovf_q;
      err_unf_d   = err_unf_q;
      if (clear) begin
         out_valid_d = 1'b0;
         err_ovf_d   = 1'b0;
         err_unf_d   = 1'b0;
      end else begin
         err_ovf_d = err_ovf_q | (bus.fwd_valid & full_s);
         err_unf_d = err_unf_q | (bus.bwd_in_valid & empty_s);
         if (pop_s) begin
            out_valid_d = 1'b1;
            out_grad_d  = pass_s ? bus.bwd_in_grad : {dataWidth{1'b0}};
         end else if (bus.bwd_out_ready) begin
            out_valid_d = 1'b0;
         end else begin
            out_valid_d = out_valid_q;
         end
      end
   end

   // Output and error registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_grad_q  <= {dataWidth{1'b0}};
         err_ovf_q   <= 1'b0;
         err_unf_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_grad_q  <= out_grad_d;
         err_ovf_q   <= err_ovf_d;
         err_unf_q   <= err_unf_d;
      end
   end

endmodule

// File: tb/tb_relu_backward.sv
// Scoreboard bench: two instances (zeroOnSat=1 and 0) share one stimulus stream.
module tb_relu_backward;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        fwd_valid = 1'b0;
   logic [31:0] fwd_x = 32'h0;
   logic        bwd_in_valid = 1'b0;
   logic [15:0] bwd_in_grad = 16'h0;
   logic        bwd_out_ready = 1'b1;
   logic [6:0]  count1, count0;
   logic        ovf1, unf1, ovf0, unf0;

   int checks = 0;
   int failures = 0;

   bit [1:0]    mq [$];
   logic [15:0] eq1 [$];
   logic [15:0] eq0 [$];
   logic [15:0] last1 = 16'h0;
   logic [15:0] last0 = 16'h0;
   bit          ovf_m = 1'b0;
   bit          unf_m = 1'b0;

   relu_backward_if #(.DATA_WIDTH(16)) if1 ();
   relu_backward_if #(.DATA_WIDTH(16)) if0 ();

   assign if1.fwd_valid = fwd_valid;       assign if0.fwd_valid = fwd_valid;
   assign if1.fwd_x = fwd_x;               assign if0.fwd_x = fwd_x;
   assign if1.bwd_in_valid = bwd_in_valid; assign if0.bwd_in_valid = bwd_in_valid;
   assign if1.bwd_in_grad = bwd_in_grad;   assign if0.bwd_in_grad = bwd_in_grad;
   assign if1.bwd_out_ready = bwd_out_ready;
   assign if0.bwd_out_ready = bwd_out_ready;

   relu_backward #(.dataWidth(16), .weightIntWidth(4), .depth(64), .zeroOnSat(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if1),
      .count(count1), .err_overflow(ovf1), .err_underflow(unf1));

   relu_backward #(.dataWidth(16), .weightIntWidth(4), .depth(64), .zeroOnSat(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(if0),
      .count(count0), .err_overflow(ovf0), .err_underflow(unf0));

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic bit [1:0] tb_mask(input logic [31:0] x);
      bit act, sat;
      act = ~x[31];
      sat = act & (x[31:27] != 5'd0);
      return {act, sat};
   endfunction

   // Reference model: check current state, then apply the coming edge's transfers.
   always @(negedge clk) begin
      bit [1:0] m;
      if (!rst_n) begin
         mq.delete(); eq1.delete(); eq0.delete();
         last1 = 16'h0; last0 = 16'h0; ovf_m = 1'b0; unf_m = 1'b0;
      end else begin
         check_eq("count1", 64'(count1), 64'(mq.size()));
         check_eq("count0", 64'(count0), 64'(mq.size()));
         check_eq("fwd_ready", 64'(if1.fwd_ready), 64'(mq.size() != 64));
         check_eq("bwd_in_ready", 64'(if1.bwd_in_ready),
                  64'((mq.size() != 0) && ((eq1.size() == 0) || bwd_out_ready)));
         check_eq("out_valid1", 64'(if1.bwd_out_valid), 64'(eq1.size() != 0));
         check_eq("out_valid0", 64'(if0.bwd_out_valid), 64'(eq1.size() != 0));
         check_eq("out_grad1", 64'(if1.bwd_out_grad), 64'((eq1.size() != 0) ? eq1[0] : last1));
         check_eq("out_grad0", 64'(if0.bwd_out_grad), 64'((eq0.size() != 0) ? eq0[0] : last0));
         check_eq("err_ovf", 64'({ovf1, ovf0}), 64'({ovf_m, ovf_m}));
         check_eq("err_unf", 64'({unf1, unf0}), 64'({unf_m, unf_m}));
         if (clear) begin
            if (eq1.size() != 0) begin
               last1 = eq1[0];
               last0 = eq0[0];
            end
            mq.delete(); eq1.delete(); eq0.delete();
            ovf_m = 1'b0; unf_m = 1'b0;
         end else begin
            if (fwd_valid && mq.size() == 64) ovf_m = 1'b1;
            if (bwd_in_valid && mq.size() == 0) unf_m = 1'b1;
            if (eq1.size() != 0 && bwd_out_ready) begin
               last1 = eq1.pop_front();
               last0 = eq0.pop_front();
            end
            if (bwd_in_valid && if1.bwd_in_ready) begin
               m = mq.pop_front();
               eq1.push_back((m[1] && !m[0]) ? bwd_in_grad : 16'h0);
               eq0.push_back(m[1] ? bwd_in_grad : 16'h0);
            end
            if (fwd_valid && if1.fwd_ready) mq.push_back(tb_mask(fwd_x));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] x);
      fwd_valid = 1'b1; fwd_x = x;
      step();
      fwd_valid = 1'b0;
   endtask

   task automatic pop(input logic [15:0] g);
      bwd_in_valid = 1'b1; bwd_in_grad = g;
      step();
      bwd_in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #22;
      check_eq("rst_count", 64'(count1), 64'd0);
      check_eq("rst_ready", 64'({if1.fwd_ready, if1.bwd_in_ready}), 64'(2'b10));
      check_eq("rst_out", 64'({if1.bwd_out_valid, if1.bwd_out_grad}), 64'd0);
      check_eq("rst_err", 64'({ovf1, unf1}), 64'd0);
      step();
      rst_n = 1'b1;
      step();

      // Basic pass-through.
      push(32'h0010_0000);
      check_eq("t1_count1", 64'(count1), 64'd1);
      pop(16'h0123);
      check_eq("t1_out", 64'({if1.bwd_out_valid, if1.bwd_out_grad}), 64'({1'b1, 16'h0123}));
      check_eq("t1_count0", 64'(count1), 64'd0);
      step();

      // Negative and saturated samples on both instances.
      push(32'hFFFF_0000);
      push(32'h0800_0000);
      pop(16'h7000);
      check_eq("t2_neg1", 64'(if1.bwd_out_grad), 64'h0);
      check_eq("t2_neg0", 64'(if0.bwd_out_grad), 64'h0);
      pop(16'h8001);
      check_eq("t2_sat1", 64'(if1.bwd_out_grad), 64'h0);
      check_eq("t2_sat0", 64'(if0.bwd_out_grad), 64'h8001);
      step();

      // Fill to full (pointers wrap), overflow, then drain at full rate.
      for (int i = 0; i < 64; i++) push($urandom >> (i % 8));
      check_eq("t3_full_ready", 64'(if1.fwd_ready), 64'd0);
      push(32'h0000_1000);
      check_eq("t3_ovf", 64'({ovf1, count1}), 64'({1'b1, 7'd64}));
      bwd_in_valid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         bwd_in_grad = 16'($urandom);
         check_eq("t3_rate", 64'(if1.bwd_in_ready), 64'd1);
         step();
      end
      bwd_in_valid = 1'b0;
      check_eq("t3_empty", 64'(count1), 64'd0);
      step();

      // Backpressure hold, then same-cycle accept on release.
      push(32'h0010_0000);
      push(32'h0020_0000);
      pop(16'h1111);
      bwd_out_ready = 1'b0;
      bwd_in_valid = 1'b1; bwd_in_grad = 16'h2222;
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq("t4_hold", 64'({if1.bwd_in_ready, if1.bwd_out_valid, if1.bwd_out_grad}),
                  64'({1'b0, 1'b1, 16'h1111}));
      end
      bwd_out_ready = 1'b1;
      #1;
      check_eq("t4_release", 64'(if1.bwd_in_ready), 64'd1);
      step();
      bwd_in_valid = 1'b0;
      check_eq("t4_next", 64'(if1.bwd_out_grad), 64'h2222);
      step();

      // Simultaneous push and pop, then underflow.
      for (int i = 0; i < 3; i++) push(32'h0001_0000 + 32'(i));
      fwd_valid = 1'b1; fwd_x = 32'h0003_0000;
      bwd_in_valid = 1'b1; bwd_in_grad = 16'h0abc;
      step();
      fwd_valid = 1'b0; bwd_in_valid = 1'b0;
      check_eq("t5_count3", 64'(count1), 64'd3);
      bwd_in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bwd_in_grad = 16'h0100 + 16'(i);
         step();
      end
      step();
      bwd_in_valid = 1'b0;
      step();
      check_eq("t5_unf", 64'({unf1, if1.bwd_out_valid}), 64'({1'b1, 1'b0}));

      // Clear with stored masks and a pending output.
      for (int i = 0; i < 11; i++) push(32'h0000_4000 + 32'(i));
      bwd_out_ready = 1'b0;
      pop(16'h5555);
      check_eq("t6_pre", 64'({if1.bwd_out_valid, count1}), 64'({1'b1, 7'd10}));
      clear = 1'b1;
      step();
      clear = 1'b0;
      bwd_out_ready = 1'b1;
      check_eq("t6_clear", 64'({count1, if1.bwd_out_valid, ovf1, unf1}), 64'({7'd0, 3'b000}));
      step();

      // Asynchronous reset mid-stream.
      for (int i = 0; i < 4; i++) push(32'h0000_0100);
      bwd_in_valid = 1'b1; bwd_in_grad = 16'h7777;
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("t7_rst", 64'({count1, if1.bwd_out_valid, if1.bwd_out_grad, ovf1, unf1}), 64'd0);
      check_eq("t7_rdy", 64'({if1.fwd_ready, if1.bwd_in_ready}), 64'(2'b10));
      bwd_in_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/relu_backward.md
Name: relu_backward

Overview:
- Backward-pass companion to the neuron ReLU activation.
- During the forward pass it records a 2-bit mask per neuron output: active (x >= 0) and saturated (positive overflow clipped).
- During the backward pass it consumes upstream gradients in the same neuron order. Each gradient is passed through when the mask says pass, otherwise zeroed.
- Sits beside the ReLU stage of a layer. Gradients leave on a valid/ready stream toward the weight-update logic.

Parameters:
- dataWidth, 16, activation and gradient width (signed fixed point).
- weightIntWidth, 4, integer bits of weight format; sets the saturation test on the 2*dataWidth sum.
- depth, 64, mask FIFO entries (max neurons per layer).
- zeroOnSat, 1, 1: saturated entries zero the gradient; 0: straight-through for saturated entries.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush of masks and output stage
- fwd_valid  in  1  forward sample valid
- fwd_x  in  2*dataWidth  signed pre-activation sum (same word the ReLU receives)
- fwd_ready  out  1  mask FIFO not full
- bwd_in_valid  in  1  upstream gradient valid
- bwd_in_grad  in  dataWidth  signed upstream gradient
- bwd_in_ready  out  1  gradient accepted this cycle
- bwd_out_valid  out  1  masked gradient valid
- bwd_out_grad  out  dataWidth  masked gradient
- bwd_out_ready  in  1  downstream accept
- count  out  $clog2(depth+1)  stored masks
- err_overflow  out  1  sticky: fwd_valid while full
- err_underflow  out  1  sticky: bwd_in_valid while empty

Behaviour:
- Reset (rst_n low, async): pointers, count, bwd_out_valid, bwd_out_grad and both error flags go to 0. Consequently fwd_ready=1 and bwd_in_ready=0.
- Mask computation on a push:
  - active = (fwd_x[2*dataWidth-1] == 0).
  - sat = active & |fwd_x[2*dataWidth-1 -: weightIntWidth+1].
- Push: occurs when fwd_valid & fwd_ready. Writes {active,sat} at wr_ptr; wr_ptr increments and wraps at depth-1 -> 0.
- fwd_ready = (count != depth), combinational from count.
- bwd_in_ready = (count != 0) & (!bwd_out_valid | bwd_out_ready).
- Pop: occurs when bwd_in_valid & bwd_in_ready. Reads the mask at rd_ptr; rd_ptr increments and wraps.
- Output register on a pop (next cycle, latency 1):
  - bwd_out_valid <= 1.
  - bwd_out_grad <= pass ? bwd_in_grad : 0, where pass = active & !(sat & zeroOnSat).
- Output hold: if bwd_out_valid & !bwd_out_ready, grad and valid hold stable. If the register is drained with no new pop, bwd_out_valid <= 0 and grad holds its last value.
- Full throughput: one pop per cycle when bwd_out_ready stays high.
- Simultaneous push and pop: both execute and count is unchanged. A pop on an empty FIFO cannot coincide with a same-cycle push; no bypass, so a pushed mask is visible the next cycle.
- Full: push blocked; fwd_valid & !fwd_ready sets err_overflow, and the sample is dropped.
- Empty: pop blocked; bwd_in_valid & count==0 sets err_underflow.
- clear: resets pointers, count, bwd_out_valid and both error flags in the same cycle. It overrides any push or pop that cycle; bwd_out_grad is not cleared.
- Mask storage may be a flop array; reads are combinational from rd_ptr.

Decomposition:
- neuron_pkg:
  - typedef relu_mask_t, a packed struct {logic active; logic sat;}.
  - function relu_mask_of(x) shared with the forward ReLU for an identical saturation test.
- Sub-module relu_mask_fifo:
  - depth-entry relu_mask_t FIFO with push, pop, clear, count, full and empty.
  - Top level adds the gradient masking, output register and error flags.

Test Plan:
- Reset, then push x=32'h0010_0000 and pop grad=16'h0123 -> bwd_out_grad=16'h0123 one cycle after the pop; count goes 1 -> 0.
- Push x=32'hFFFF_0000 (negative) and x=32'h0800_0000 (saturated, zeroOnSat=1); pop grads 16'h7000 and 16'h8001 -> outputs 16'h0000, 16'h0000. Rerun with zeroOnSat=0 -> 16'h0000, 16'h8001.
- Push 64 masks -> fwd_ready=0. A 65th fwd_valid sets err_overflow=1 and count stays 64. Pop all 64 in order with bwd_out_ready=1 -> one output per cycle, ordering matches the push sequence across pointer wrap.
- Hold bwd_out_ready=0 with a valid output -> bwd_in_ready=0, output stable for 5 cycles. Release -> next gradient is accepted in the same cycle.
- Simultaneous push and pop at count=3 -> count stays 3. bwd_in_valid at count=0 -> err_underflow=1 and no output.
- Assert clear with count=10 and bwd_out_valid=1 -> next cycle count=0, bwd_out_valid=0, errors=0. Assert rst_n low mid-stream -> all outputs are at reset values immediately.
